// File: rtl/lsu_ctrl_if.sv
// Request, memory-side and response signal bundle for the load/store control stage.
// The slave modport is the lsu_ctrl view; the master modport is its surroundings.
interface lsu_ctrl_if;
   logic        i_req_valid;
   logic        o_req_ready;
   logic        i_req_is_load;
   logic        i_req_is_store;
   logic [2:0]  i_req_func3;
   logic [31:0] i_req_addr;
   logic [31:0] i_req_wdata;

   logic [2:0]  o_mem_func3;
   logic [15:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [3:0]  o_mem_bmask_align;
   logic [3:0]  o_mem_bmask_misalign;
   logic        o_mem_wren;
   logic        o_mem_rden;
   logic [31:0] i_mem_rdata;

   logic        o_rsp_valid;
   logic        i_rsp_ready;
   logic [31:0] o_rsp_rdata;
   logic        o_rsp_err;

   modport slave (
      input  i_req_valid, i_req_is_load, i_req_is_store, i_req_func3, i_req_addr, i_req_wdata,
      input  i_mem_rdata, i_rsp_ready,
      output o_req_ready, o_mem_func3, o_mem_addr, o_mem_wdata,
      output o_mem_bmask_align, o_mem_bmask_misalign, o_mem_wren, o_mem_rden,
      output o_rsp_valid, o_rsp_rdata, o_rsp_err
   );

   modport master (
      output i_req_valid, i_req_is_load, i_req_is_store, i_req_func3, i_req_addr, i_req_wdata,
      output i_mem_rdata, i_rsp_ready,
      input  o_req_ready, o_mem_func3, o_mem_addr, o_mem_wdata,
      input  o_mem_bmask_align, o_mem_bmask_misalign, o_mem_wren, o_mem_rden,
      input  o_rsp_valid, o_rsp_rdata, o_rsp_err
   );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store control stage: validates one request at a time, drives the data memory
// controls and returns a registered load-data/error response over valid/ready.
module lsu_ctrl #(
   parameter int MEM_BYTES = 2048,
   parameter int CNT_W     = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   lsu_ctrl_if.slave        bus,
   output logic             o_stall,
   output logic [CNT_W-1:0] o_cnt_load,
   output logic [CNT_W-1:0] o_cnt_store,
   output logic [CNT_W-1:0] o_cnt_err
);
   typedef enum logic [1:0] {IDLE, CAPTURE, RESP} state_t;

   localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

   state_t      state_reg, state_next;
   logic [31:0] rdata_reg;
   logic        err_reg;

   logic        accept;
   logic        req_err;
   logic        mem_go;
   logic [2:0]  acc_size;
   logic        func_ok;
   logic [32:0] end_addr;
   logic [7:0]  lane_span;

   // Request decode: size, legality and the last byte touched by the access.
   always_comb begin
      acc_size = 3'd1;
      func_ok  = 1'b0;
      case (bus.i_req_func3[1:0])
         2'b01:   acc_size = 3'd2;
         2'b10:   acc_size = 3'd4;
         default: acc_size = 3'd1;
      endcase
      if (bus.i_req_is_load)
         func_ok = (bus.i_req_func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      else
         func_ok = (bus.i_req_func3 inside {3'b000, 3'b001, 3'b010});
      end_addr = {1'b0, bus.i_req_addr} + 33'(acc_size) - 33'd1;
      req_err  = (bus.i_req_is_load == bus.i_req_is_store)
               | ~func_ok
               | (bus.i_req_is_store && bus.i_req_func3 == 3'b001 && bus.i_req_addr[1:0] == 2'b01)
               | (end_addr >= MEM_LIMIT);
   end

   assign accept = bus.i_req_valid && (state_reg == IDLE);
   // Reset level gates the enables so nothing reaches memory while reset is held.
   assign mem_go = accept && !req_err && i_reset;

   // Bytes past lane 3 spill into the following word.
   always_comb begin
      lane_span = 8'b0000_0001;
      case (acc_size)
         3'd2:    lane_span = 8'b0000_0011;
         3'd4:    lane_span = 8'b0000_1111;
         default: lane_span = 8'b0000_0001;
      endcase
      lane_span = lane_span << bus.i_req_addr[1:0];
   end

   assign bus.o_mem_func3 = bus.i_req_func3;
   assign bus.o_mem_addr  = bus.i_req_addr[15:0];
   assign bus.o_mem_wdata = bus.i_req_wdata;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next               = state_reg;
      bus.o_req_ready          = 1'b0;
      bus.o_rsp_valid          = 1'b0;
      bus.o_mem_wren           = 1'b0;
      bus.o_mem_rden           = 1'b0;
      bus.o_mem_bmask_align    = 4'b0000;
      bus.o_mem_bmask_misalign = 4'b0000;
      case (state_reg)
         IDLE: begin
            bus.o_req_ready = 1'b1;
            bus.o_mem_rden  = mem_go && bus.i_req_is_load;
            bus.o_mem_wren  = mem_go && bus.i_req_is_store;
            if (mem_go && bus.i_req_is_store) begin
               bus.o_mem_bmask_align    = lane_span[3:0];
               bus.o_mem_bmask_misalign = lane_span[7:4];
            end
            if (accept)
               state_next = (bus.i_req_is_load && !req_err) ? CAPTURE : RESP;
         end
         CAPTURE: state_next = RESP;
         RESP: begin
            bus.o_rsp_valid = 1'b1;
            if (bus.i_rsp_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         rdata_reg <= 32'd0;
         err_reg   <= 1'b0;
      end else if (state_reg == IDLE && accept) begin
         rdata_reg <= 32'd0;
         err_reg   <= req_err;
      end else if (state_reg == CAPTURE) begin
         rdata_reg <= bus.i_mem_rdata;
         err_reg   <= 1'b0;
      end
   end

   assign bus.o_rsp_rdata = rdata_reg;
   assign bus.o_rsp_err   = err_reg;
   assign o_stall         = (state_reg != IDLE);

   // Event counters: 0 = load, 1 = store, 2 = error.
   logic [2:0]       cnt_inc;
   logic [CNT_W-1:0] cnt_reg [3];

   assign cnt_inc[0] = accept && !req_err && bus.i_req_is_load;
   assign cnt_inc[1] = accept && !req_err && bus.i_req_is_store;
   assign cnt_inc[2] = accept && req_err;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
         always_ff @(posedge i_clk or negedge i_reset) begin
            if (!i_reset)
               cnt_reg[gi] <= '0;
            else if (cnt_inc[gi] && cnt_reg[gi] != {CNT_W{1'b1}})
               cnt_reg[gi] <= cnt_reg[gi] + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   endgenerate

   assign o_cnt_load  = cnt_reg[0];
   assign o_cnt_store = cnt_reg[1];
   assign o_cnt_err   = cnt_reg[2];
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store control stage that sits directly upstream of the 2 KiB data memory in the pipeline. It accepts one load or store request at a time from the MEM-stage pipeline register and validates it. It generates the aligned and misaligned byte masks plus the memory control signals. It then returns a registered response (load data or error) through a valid/ready handshake and stalls the pipeline while the request is busy.

## Interface
- MEM_BYTES, 2048: data memory size in bytes. Must be a power of two, ≥ 8.
- CNT_W, 16: width of the saturating statistics counters.

- i_clk  in  1  clock; all state updates on the rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_req_valid  in  1  request present
- o_req_ready  out  1  stage can accept a request
- i_req_is_load / i_req_is_store  in  1 each  access type
- i_req_func3  in  3  RV32 funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- i_req_addr  in  32  byte address
- i_req_wdata  in  32  store data, unshifted (low bytes significant)
- o_mem_func3  out  3  to memory
- o_mem_addr  out  16  to memory, = i_req_addr[15:0]
- o_mem_wdata  out  32  to memory, = i_req_wdata
- o_mem_bmask_align / o_mem_bmask_misalign  out  4 each  byte-lane masks
- o_mem_wren / o_mem_rden  out  1 each  memory enables
- i_mem_rdata  in  32  memory load data, valid the cycle after rden
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  consumer takes response
- o_rsp_rdata  out  32  load data (0 for stores and errors)
- o_rsp_err  out  1  request was rejected
- o_stall  out  1  = busy (state ≠ IDLE)
- o_cnt_load / o_cnt_store / o_cnt_err  out  CNT_W each  saturating event counters

## Operation
- FSM states: IDLE, CAPTURE, RESP. o_req_ready = (state == IDLE).
- Accept = i_req_valid & o_req_ready. The memory outputs are combinational from the request inputs in IDLE. Outside IDLE or when not accepting: wren = rden = 0 and masks = 0.
- Error (err = 1) when any of the following hold:
  - is_load and is_store are both 1, or both 0.
  - A load with func3 ∉ {000, 001, 010, 100, 101}.
  - A store with func3 ∉ {000, 001, 010}.
  - A store halfword at offset 1.
  - addr ≥ MEM_BYTES.
  - addr + size − 1 ≥ MEM_BYTES, for a word or halfword access that crosses into the next word.
- On error, no memory enable is raised.
- Store masks (align / misalign), where offset = addr[1:0]:
  - Byte at offset k: align = 1<<k, misalign = 0000.
  - Half at offset 0: 0011/0000. Offset 2: 1100/0000. Offset 3: 1000/0001. Offset 1: error.
  - Word at offset 0: 1111/0000. Offset 1: 1110/0001. Offset 2: 1100/0011. Offset 3: 1000/0111.
- Load masks are 0.
- Transitions:
  - IDLE, accepting a valid load → CAPTURE.
  - IDLE, accepting a valid store or an error → RESP. r_rdata = 0, r_err = err.
  - CAPTURE → RESP. r_rdata = i_mem_rdata, r_err = 0.
  - RESP: o_rsp_valid = 1. If i_rsp_ready → IDLE, otherwise hold with outputs stable.
- Counters increment at accept: load, store, or error, whichever applies. An error counts only in o_cnt_err. Each counter saturates at 2^CNT_W − 1.

## Timing
- Reset (asynchronous assert, synchronous release): state = IDLE. r_rdata, r_err, o_rsp_valid and all counters are 0. mem wren, rden and masks are 0. o_req_ready is 1.
- Store: memory is written at the accept edge (cycle N). o_rsp_valid is 1 from cycle N+1.
- Load: rden is high in cycle N and memory data is valid in N+1, when it is captured. o_rsp_valid is 1 from cycle N+2.
- Throughput: at best one store per 2 cycles and one load per 3 cycles. A new request is accepted no earlier than the cycle after the RESP handshake.
- i_rsp_ready is held low: RESP, rdata and err stay stable. No new request is accepted and no memory enable is raised.
- Reset asserted mid-request: the FSM returns to IDLE at once, the pending response is dropped, and enables are forced to 0 combinationally.

## Test plan
- Reset → o_req_ready = 1, o_rsp_valid = 0, all counters 0, wren = rden = 0.
- SW 0xDEADBEEF @0x012 → align 1100, misalign 0011, wren for 1 cycle, response at N+1 with err = 0. Then LW @0x012 → rden at N, o_rsp_valid at N+2, rdata = 0xDEADBEEF.
- SH @0x003 → masks 1000/0001. SH @0x001 → err = 1, no wren, o_cnt_err = 1, o_cnt_store unchanged.
- LW @0x7FD and SB @0x800 → err = 1, no memory enables, rdata = 0.
- RESP with i_rsp_ready low for 5 cycles → o_rsp_valid and rdata constant, o_req_ready = 0, o_stall = 1. Raise ready → IDLE on the next cycle.
- Assert i_reset during CAPTURE → IDLE immediately, o_rsp_valid = 0. Separately, force the load counter to 0xFFFF and issue a load → counter stays at 0xFFFF.
